music_seq: RTL



---
 rtl/music_pkg.sv | 17 +
 rtl/music_seq_tone_div.sv | 34 +++
 rtl/music_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// music_pkg: sequencer state encoding, pitch half-periods, default song table and note field helpers
package music_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;
  localparam logic [17:0] TONE_HALF [8] = '{
    18'd0, 18'd191110, 18'd170265, 18'd151685, 18'd143172, 18'd127551, 18'd113636, 18'd101239
  };
  localparam logic [5:0] NOTE_ROM [16] = '{
    6'o11, 6'o21, 6'o31, 6'o41, 6'o52, 6'o00, 6'o00, 6'o00,
    6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00
  };
  function automatic logic [2:0] note_tone(input logic [5:0] n);
    return n[5:3];
  endfunction
  function automatic logic [2:0] note_dur(input logic [5:0] n);
    return n[2:0];
  endfunction
endpackage

// File: rtl/music_seq_tone_div.sv
// tone_div: programmable square-wave divider (clk, rst, en, half in; out toggles every half cycles, 0 when idle)
module tone_div #(
  parameter int DIV_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] half,
  output logic             out
);
  logic [DIV_W-1:0] r_cnt, r_half;
  logic r_out;
  logic w_hit;
  assign w_hit = r_cnt == half - DIV_W'(1);
  assign out = r_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_half <= '0;
      r_out <= 1'b0;
    end else begin
      r_half <= half;
      if (!en || half != r_half) begin
        r_cnt <= '0;
        r_out <= 1'b0;
      end else if (w_hit) begin
        r_cnt <= '0;
        r_out <= ~r_out;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end
endmodule

// File: rtl/music_seq.sv
// music_seq: melody sequencer (start/stop/loop_en in; speaker, busy, done, note_idx, tone_code out)
module music_seq
  import music_pkg::*;
#(
  parameter int BEAT_DIV = 25_000_000,
  parameter int GAP_CYC  = 2_500_000,
  parameter int SCALE_SH = 0,
  parameter int DIV_W    = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic       speaker,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx,
  output logic [2:0] tone_code
);
  localparam int BW = $clog2(7 * BEAT_DIV + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  state_t r_state, w_state_n;
  logic [BW-1:0] r_beat, w_beat_n;
  logic [GW-1:0] r_gap, w_gap_n;
  logic [3:0] r_idx, w_idx_n;
  logic [2:0] r_tone, w_tone_n, r_dur, w_dur_n, r_code, w_code_n;
  logic r_wrap, w_wrap_n;
  logic [5:0] w_note;
  logic w_eos, w_play_end, w_gap_end, w_div_en;
  logic [DIV_W-1:0] w_half;
  assign w_note = NOTE_ROM[r_idx];
  assign w_eos = r_wrap || note_dur(w_note) == 3'd0;
  assign w_play_end = r_beat == BW'(r_dur) * BW'(BEAT_DIV) - BW'(1);
  assign w_gap_end = r_gap == GW'(GAP_CYC - 1);
  assign w_div_en = r_state == S_PLAY && w_state_n == S_PLAY && r_tone != 3'd0;
  assign w_half = DIV_W'(TONE_HALF[w_tone_n] >> SCALE_SH);
  assign busy = r_state == S_LOAD || r_state == S_PLAY || r_state == S_GAP;
  assign done = r_state == S_DONE;
  assign note_idx = r_idx;
  assign tone_code = r_code;
  always_comb begin
    w_state_n = r_state;
    w_beat_n = r_beat;
    w_gap_n = r_gap;
    w_idx_n = r_idx;
    w_tone_n = r_tone;
    w_dur_n = r_dur;
    w_code_n = r_code;
    w_wrap_n = r_wrap;
    case (r_state)
      S_IDLE: begin
        w_state_n = start ? S_LOAD : S_IDLE;
        w_idx_n = start ? 4'd0 : r_idx;
      end
      S_LOAD: begin
        w_wrap_n = 1'b0;
        w_tone_n = note_tone(w_note);
        w_dur_n = note_dur(w_note);
        w_beat_n = '0;
        w_state_n = !w_eos ? S_PLAY : loop_en ? S_LOAD : S_DONE;
        w_code_n = w_eos ? r_code : note_tone(w_note);
        w_idx_n = w_eos ? 4'd0 : r_idx;
      end
      S_PLAY: begin
        w_state_n = w_play_end ? S_GAP : S_PLAY;
        w_code_n = w_play_end ? 3'd0 : r_code;
        w_beat_n = w_play_end ? r_beat : r_beat + BW'(1);
        w_gap_n = '0;
      end
      S_GAP: begin
        w_state_n = w_gap_end ? S_LOAD : S_GAP;
        w_idx_n = w_gap_end ? r_idx + 4'd1 : r_idx;
        w_wrap_n = w_gap_end && r_idx == 4'd15;
        w_gap_n = w_gap_end ? r_gap : r_gap + GW'(1);
      end
      default: w_state_n = S_IDLE;
    endcase
    if (stop) begin
      w_state_n = S_IDLE;
      w_idx_n = 4'd0;
      w_code_n = 3'd0;
      w_wrap_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_beat <= '0;
      r_gap <= '0;
      r_idx <= '0;
      r_tone <= '0;
      r_dur <= '0;
      r_code <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_beat <= w_beat_n;
      r_gap <= w_gap_n;
      r_idx <= w_idx_n;
      r_tone <= w_tone_n;
      r_dur <= w_dur_n;
      r_code <= w_code_n;
      r_wrap <= w_wrap_n;
    end
  end
  tone_div #(.DIV_W(DIV_W)) u_div (
    .clk (clk),
    .rst (rst),
    .en  (w_div_en),
    .half(w_half),
    .out (speaker)
  );
endmodule
